// File: rtl/fft_frame_sequencer.sv
// Frames a continuous mono audio stream into fixed-length packets for a variable-size FFT core.
// It drives the core sink (sop/eop, fftpts_in, inverse, imag = 0), unpacks the core source into
// indexed bins, checks the source framing and counts completed output frames.
//
// Ports
//   clk, reset        : single clock, asynchronous active-high reset
//   enable, cfg_*     : framing enable and per-frame FFT size/direction (sampled at frame starts)
//   aud_*             : audio sample input handshake
//   fft_sink_*        : FFT core sink interface (plus fft_fftpts_in, fft_inverse)
//   fft_src_*         : FFT core source interface (plus fft_fftpts_out)
//   bin_*             : indexed bin output stream
//   frame_count       : completed output frames (wraps)
//   cfg_err/frame_err : sticky error flags, cleared only by reset
module fft_frame_sequencer #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned PTS_W  = 11,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [PTS_W-1:0]  cfg_pts,
  input  logic              cfg_inverse,
  input  logic              aud_valid,
  output logic              aud_ready,
  input  logic [DATA_W-1:0] aud_data,
  output logic              fft_sink_valid,
  input  logic              fft_sink_ready,
  output logic              fft_sink_sop,
  output logic              fft_sink_eop,
  output logic [DATA_W-1:0] fft_sink_real,
  output logic [DATA_W-1:0] fft_sink_imag,
  output logic [1:0]        fft_sink_error,
  output logic [PTS_W-1:0]  fft_fftpts_in,
  output logic              fft_inverse,
  input  logic              fft_src_valid,
  output logic              fft_src_ready,
  input  logic              fft_src_sop,
  input  logic              fft_src_eop,
  input  logic [1:0]        fft_src_error,
  input  logic [OUT_W-1:0]  fft_src_real,
  input  logic [OUT_W-1:0]  fft_src_imag,
  input  logic [PTS_W-1:0]  fft_fftpts_out,
  output logic              bin_valid,
  input  logic              bin_ready,
  output logic [OUT_W-1:0]  bin_real,
  output logic [OUT_W-1:0]  bin_imag,
  output logic [PTS_W-1:0]  bin_index,
  output logic              bin_last,
  output logic [CNT_W-1:0]  frame_count,
  output logic              cfg_err,
  output logic              frame_err
);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e              state_q, state_d;
  logic [PTS_W-1:0]    pts_q;          // size of the frame currently being fed
  logic                inv_q;
  logic [PTS_W-1:0]    sample_cnt_q;
  logic                sink_valid_q, sink_sop_q, sink_eop_q;
  logic [DATA_W-1:0]   sink_data_q;
  logic [PTS_W-1:0]    fftpts_in_q;
  logic                inverse_q;
  logic                cfg_err_q, frame_err_q;
  logic [PTS_W-1:0]    out_cnt_q;
  logic [CNT_W-1:0]    frame_count_q;

  logic             cfg_legal, aud_accept, sink_last, boundary;
  logic             latch_cfg, set_cfg_err;
  logic             src_beat, src_bad;
  logic [PTS_W-1:0] cfg_pts_m1, pts_out_m1;

  // Legal size: power of two within 64..1024.
  assign cfg_pts_m1 = cfg_pts - PTS_W'(1);
  assign cfg_legal  = ((cfg_pts & cfg_pts_m1) == '0) && (cfg_pts >= PTS_W'(64)) &&
                      (cfg_pts <= PTS_W'(1024));

  assign aud_accept = aud_valid & aud_ready;
  assign sink_last  = (sample_cnt_q == pts_q - PTS_W'(1));
  assign boundary   = (state_q == StStream) & aud_accept & sink_last;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    latch_cfg   = 1'b0;
    set_cfg_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          if (cfg_legal) begin
            state_d   = StStream;
            latch_cfg = 1'b1;
          end else begin
            set_cfg_err = 1'b1;
          end
        end
      end
      StStream: begin
        if (boundary) begin
          if (enable && cfg_legal) begin
            latch_cfg = 1'b1;
          end else if (enable) begin
            set_cfg_err = 1'b1;
            state_d     = StIdle;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave only once the held eop beat has been taken by the core.
        if (!sink_valid_q || fft_sink_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    aud_ready = (state_q == StStream) & (!sink_valid_q | fft_sink_ready);
  end

  // Sink stage and frame configuration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pts_q        <= '0;
      inv_q        <= 1'b0;
      sample_cnt_q <= '0;
      sink_valid_q <= 1'b0;
      sink_sop_q   <= 1'b0;
      sink_eop_q   <= 1'b0;
      sink_data_q  <= '0;
      fftpts_in_q  <= '0;
      inverse_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      if (aud_accept) begin
        sink_valid_q <= 1'b1;
        sink_data_q  <= aud_data;
        sink_sop_q   <= (sample_cnt_q == '0);
        sink_eop_q   <= sink_last;
        sample_cnt_q <= sink_last ? '0 : sample_cnt_q + PTS_W'(1);
        // Size/direction shown to the core change only with a new sop beat.
        if (sample_cnt_q == '0) begin
          fftpts_in_q <= pts_q;
          inverse_q   <= inv_q;
        end
      end else if (fft_sink_ready) begin
        sink_valid_q <= 1'b0;
      end
      if (latch_cfg) begin
        pts_q <= cfg_pts;
        inv_q <= cfg_inverse;
        if (state_q == StIdle) begin
          sample_cnt_q <= '0;
          fftpts_in_q  <= cfg_pts;
          inverse_q    <= cfg_inverse;
        end
      end
      if (set_cfg_err) cfg_err_q <= 1'b1;
    end
  end

  // Source side: bin indexing, frame counting, framing checks
  assign src_beat   = fft_src_valid & bin_ready;
  assign pts_out_m1 = fft_fftpts_out - PTS_W'(1);
  assign src_bad    = (fft_src_sop && (out_cnt_q != '0)) ||
                      (fft_src_eop && (out_cnt_q != pts_out_m1)) ||
                      (fft_src_error != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt_q     <= '0;
      frame_count_q <= '0;
      frame_err_q   <= 1'b0;
    end else if (src_beat) begin
      if (fft_src_eop) begin
        out_cnt_q     <= '0;
        frame_count_q <= frame_count_q + CNT_W'(1);
      end else begin
        out_cnt_q <= out_cnt_q + PTS_W'(1);
      end
      if (src_bad) frame_err_q <= 1'b1;
    end
  end

  assign fft_sink_valid = sink_valid_q;
  assign fft_sink_sop   = sink_sop_q;
  assign fft_sink_eop   = sink_eop_q;
  assign fft_sink_real  = sink_data_q;
  assign fft_sink_imag  = '0;
  assign fft_sink_error = 2'b00;
  assign fft_fftpts_in  = fftpts_in_q;
  assign fft_inverse    = inverse_q;
  assign fft_src_ready  = bin_ready;
  assign bin_valid      = fft_src_valid;
  assign bin_real       = fft_src_real;
  assign bin_imag       = fft_src_imag;
  assign bin_index      = out_cnt_q;
  assign bin_last       = fft_src_eop;
  assign frame_count    = frame_count_q;
  assign cfg_err        = cfg_err_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed testbench for fft_frame_sequencer: sink framing, stalls, reconfiguration,
// enable drop, illegal sizes and source-side framing checks.
module tb_fft_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [10:0] cfg_pts;
  logic        cfg_inverse;
  logic        aud_valid;
  logic        aud_ready;
  logic [23:0] aud_data;
  logic        fft_sink_valid, fft_sink_ready, fft_sink_sop, fft_sink_eop;
  logic [23:0] fft_sink_real, fft_sink_imag;
  logic [1:0]  fft_sink_error;
  logic [10:0] fft_fftpts_in;
  logic        fft_inverse;
  logic        fft_src_valid, fft_src_ready, fft_src_sop, fft_src_eop;
  logic [1:0]  fft_src_error;
  logic [31:0] fft_src_real, fft_src_imag;
  logic [10:0] fft_fftpts_out;
  logic        bin_valid, bin_ready, bin_last;
  logic [31:0] bin_real, bin_imag;
  logic [10:0] bin_index;
  logic [15:0] frame_count;
  logic        cfg_err, frame_err;

  fft_frame_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .cfg_pts        (cfg_pts),
    .cfg_inverse    (cfg_inverse),
    .aud_valid      (aud_valid),
    .aud_ready      (aud_ready),
    .aud_data       (aud_data),
    .fft_sink_valid (fft_sink_valid),
    .fft_sink_ready (fft_sink_ready),
    .fft_sink_sop   (fft_sink_sop),
    .fft_sink_eop   (fft_sink_eop),
    .fft_sink_real  (fft_sink_real),
    .fft_sink_imag  (fft_sink_imag),
    .fft_sink_error (fft_sink_error),
    .fft_fftpts_in  (fft_fftpts_in),
    .fft_inverse    (fft_inverse),
    .fft_src_valid  (fft_src_valid),
    .fft_src_ready  (fft_src_ready),
    .fft_src_sop    (fft_src_sop),
    .fft_src_eop    (fft_src_eop),
    .fft_src_error  (fft_src_error),
    .fft_src_real   (fft_src_real),
    .fft_src_imag   (fft_src_imag),
    .fft_fftpts_out (fft_fftpts_out),
    .bin_valid      (bin_valid),
    .bin_ready      (bin_ready),
    .bin_real       (bin_real),
    .bin_imag       (bin_imag),
    .bin_index      (bin_index),
    .bin_last       (bin_last),
    .frame_count    (frame_count),
    .cfg_err        (cfg_err),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        sop;
    logic        eop;
    logic [10:0] pts;
    logic        inv;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  adv;
  logic  stall;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  // One clock: drive after the edge, observe sink/audio handshakes on the falling edge.
  task automatic step();
    beat_t b;
    @(posedge clk); #1;
    if (adv) aud_data = aud_data + 24'd1;
    if (stall) fft_sink_ready = ~fft_sink_ready;
    @(negedge clk);
    cyc++;
    if (fft_sink_valid && fft_sink_ready) begin
      b.d = fft_sink_real; b.sop = fft_sink_sop; b.eop = fft_sink_eop;
      b.pts = fft_fftpts_in; b.inv = fft_inverse; b.cyc = cyc;
      beats.push_back(b);
    end
    adv = aud_valid && aud_ready;
  endtask

  task automatic run_until(input int n, input int max_cycles, output logic timed_out);
    int k = 0;
    while (beats.size() < n && k < max_cycles) begin
      step();
      k++;
    end
    timed_out = (beats.size() < n);
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1; enable = 1'b0; cfg_pts = 11'd64; cfg_inverse = 1'b0;
    aud_valid = 1'b1; aud_data = 24'd1; fft_sink_ready = 1'b1;
    fft_src_valid = 1'b0; fft_src_sop = 1'b0; fft_src_eop = 1'b0; fft_src_error = 2'b00;
    fft_src_real = '0; fft_src_imag = '0; fft_fftpts_out = 11'd64; bin_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    beats.delete(); adv = 1'b0; stall = 1'b0;
  endtask

  // Source-side stimulus: present one beat (transfers at the next edge).
  task automatic src_beat(input logic sop, input logic eop, input logic [1:0] err);
    @(posedge clk); #1;
    fft_src_valid = 1'b1; fft_src_sop = sop; fft_src_eop = eop; fft_src_error = err;
    bin_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic src_idle();
    @(posedge clk); #1;
    fft_src_valid = 1'b0; fft_src_sop = 1'b0; fft_src_eop = 1'b0; fft_src_error = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({aud_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_sink: actual=%b required=0000",
               {aud_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop});
    end
    checks++;
    if (fft_fftpts_in !== 11'd0 || fft_inverse !== 1'b0 || fft_sink_real !== 24'd0) begin
      errors++;
      $display("FAIL reset_cfg: actual pts=%0d inv=%b real=%0d required 0/0/0",
               fft_fftpts_in, fft_inverse, fft_sink_real);
    end
    checks++;
    if (frame_count !== 16'd0 || cfg_err !== 1'b0 || frame_err !== 1'b0 || bin_index !== 11'd0)
    begin
      errors++;
      $display("FAIL reset_status: actual cnt=%0d cfg_err=%b frame_err=%b idx=%0d required 0",
               frame_count, cfg_err, frame_err, bin_index);
    end
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (aud_ready !== 1'b0 || beats.size() != 0) begin
      errors++;
      $display("FAIL idle_disabled: actual aud_ready=%b beats=%0d required 0/0",
               aud_ready, beats.size());
    end
  endtask

  task automatic test_basic_frames();
    logic to;
    int nsop = 0, neop = 0, bad = 0;
    do_reset();
    enable = 1'b1; cfg_pts = 11'd64;
    run_until(128, 400, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout: actual beats=%0d required 128", beats.size());
      return;
    end
    for (int i = 0; i < 128; i++) begin
      if (beats[i].sop) nsop++;
      if (beats[i].eop) neop++;
      if (beats[i].d !== 24'(i + 1) || beats[i].pts !== 11'd64) bad++;
    end
    checks++;
    if (!(beats[0].sop && beats[64].sop && nsop == 2)) begin
      errors++;
      $display("FAIL basic_sop: actual sop0=%b sop64=%b nsop=%0d required 1/1/2",
               beats[0].sop, beats[64].sop, nsop);
    end
    checks++;
    if (!(beats[63].eop && beats[127].eop && neop == 2)) begin
      errors++;
      $display("FAIL basic_eop: actual eop63=%b eop127=%b neop=%0d required 1/1/2",
               beats[63].eop, beats[127].eop, neop);
    end
    checks++;
    if (beats[127].cyc - beats[0].cyc != 127) begin
      errors++;
      $display("FAIL basic_no_bubble: actual span=%0d required 127",
               beats[127].cyc - beats[0].cyc);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_data: actual bad_beats=%0d required 0", bad);
    end
  endtask

  task automatic test_stall();
    logic        held_pend = 1'b0;
    logic [23:0] hd;
    logic        hs, he;
    int          k = 0, bad = 0, holdbad = 0;
    do_reset();
    enable = 1'b1; cfg_pts = 11'd64; stall = 1'b1;
    while (beats.size() < 256 && k < 1200) begin
      step();
      k++;
      if (held_pend) begin
        if (fft_sink_valid !== 1'b1 || fft_sink_real !== hd || fft_sink_sop !== hs ||
            fft_sink_eop !== he) holdbad++;
      end
      held_pend = fft_sink_valid && !fft_sink_ready;
      hd = fft_sink_real; hs = fft_sink_sop; he = fft_sink_eop;
    end
    stall = 1'b0;
    checks++;
    if (beats.size() < 256) begin
      errors++;
      $display("FAIL stall_timeout: actual beats=%0d required 256", beats.size());
      return;
    end
    checks++;
    if (holdbad != 0) begin
      errors++;
      $display("FAIL stall_hold: actual unstable_cycles=%0d required 0", holdbad);
    end
    for (int i = 0; i < 256; i++) begin
      if (beats[i].d !== 24'(i + 1) || beats[i].sop !== (i % 64 == 0) ||
          beats[i].eop !== (i % 64 == 63)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_scoreboard: actual bad_beats=%0d required 0", bad);
    end
  endtask

  task automatic test_reconfig();
    logic to;
    do_reset();
    enable = 1'b1; cfg_pts = 11'd64;
    run_until(10, 50, to);
    cfg_pts = 11'd1024; cfg_inverse = 1'b1;
    run_until(1088, 1300, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL reconfig_timeout: actual beats=%0d required 1088", beats.size());
      return;
    end
    checks++;
    if (!(beats[63].eop && !beats[62].eop && beats[63].pts == 11'd64 && !beats[0].inv)) begin
      errors++;
      $display("FAIL reconfig_first: actual eop62=%b eop63=%b pts63=%0d inv0=%b required 0/1/64/0",
               beats[62].eop, beats[63].eop, beats[63].pts, beats[0].inv);
    end
    checks++;
    if (!(beats[64].sop && beats[64].pts == 11'd1024 && beats[64].inv &&
          beats[64].cyc - beats[63].cyc == 1)) begin
      errors++;
      $display("FAIL reconfig_second_sop: actual sop=%b pts=%0d inv=%b gap=%0d required 1/1024/1/1",
               beats[64].sop, beats[64].pts, beats[64].inv, beats[64].cyc - beats[63].cyc);
    end
    checks++;
    if (!(beats[1087].eop && !beats[1086].eop)) begin
      errors++;
      $display("FAIL reconfig_eop1023: actual eop1086=%b eop1087=%b required 0/1",
               beats[1086].eop, beats[1087].eop);
    end
  endtask

  task automatic test_enable_drop();
    logic to;
    do_reset();
    enable = 1'b1; cfg_pts = 11'd128;
    run_until(10, 50, to);
    enable = 1'b0;
    run_until(128, 400, to);
    repeat (20) step();
    checks++;
    if (beats.size() != 128) begin
      errors++;
      $display("FAIL drop_beats: actual=%0d required 128", beats.size());
      return;
    end
    checks++;
    if (!(beats[127].eop && !beats[126].eop)) begin
      errors++;
      $display("FAIL drop_eop: actual eop126=%b eop127=%b required 0/1",
               beats[126].eop, beats[127].eop);
    end
    checks++;
    if (aud_ready !== 1'b0 || fft_sink_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: actual aud_ready=%b sink_valid=%b required 0/0",
               aud_ready, fft_sink_valid);
    end
  endtask

  task automatic test_illegal_cfg();
    logic [10:0] sizes [3];
    sizes[0] = 11'd100; sizes[1] = 11'd32; sizes[2] = 11'd2047;
    for (int s = 0; s < 3; s++) begin
      do_reset();
      enable = 1'b1; cfg_pts = sizes[s];
      repeat (20) step();
      checks++;
      if (cfg_err !== 1'b1 || beats.size() != 0 || aud_ready !== 1'b0) begin
        errors++;
        $display("FAIL illegal_cfg_%0d: actual cfg_err=%b beats=%0d aud_ready=%b required 1/0/0",
                 sizes[s], cfg_err, beats.size(), aud_ready);
      end
    end
    enable = 1'b0; cfg_pts = 11'd64;
    repeat (3) step();
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_sticky: actual=%b required 1", cfg_err);
    end
  endtask

  task automatic test_reset_midframe();
    logic to;
    do_reset();
    enable = 1'b1; cfg_pts = 11'd64;
    run_until(20, 60, to);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (fft_sink_valid !== 1'b0 || aud_ready !== 1'b0 || fft_fftpts_in !== 11'd0) begin
      errors++;
      $display("FAIL reset_async: actual sink_valid=%b aud_ready=%b pts=%0d required 0/0/0",
               fft_sink_valid, aud_ready, fft_fftpts_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_source_clean();
    int i = 0, k = 0, bad = 0;
    do_reset();
    fft_fftpts_out = 11'd64;
    while (i < 64 && k < 300) begin
      @(posedge clk); #1;
      fft_src_valid = 1'b1; fft_src_sop = (i == 0); fft_src_eop = (i == 63);
      fft_src_real = 32'(i * 5); fft_src_imag = 32'(1000 - i);
      bin_ready = (k % 3 != 0);
      @(negedge clk);
      if (bin_index !== 11'(i) || bin_valid !== 1'b1 || bin_last !== (i == 63) ||
          bin_real !== 32'(i * 5) || bin_imag !== 32'(1000 - i) || fft_src_ready !== bin_ready)
        bad++;
      if (bin_ready) i++;
      k++;
    end
    src_idle();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL src_passthrough: actual bad_cycles=%0d required 0", bad);
    end
    checks++;
    if (frame_count !== 16'd1 || frame_err !== 1'b0 || bin_index !== 11'd0) begin
      errors++;
      $display("FAIL src_clean_frame: actual cnt=%0d err=%b idx=%0d required 1/0/0",
               frame_count, frame_err, bin_index);
    end
  endtask

  task automatic test_source_errors();
    do_reset();
    fft_fftpts_out = 11'd64;
    for (int i = 0; i <= 30; i++) begin
      src_beat(i == 0, i == 30, 2'b00);
      if (i == 30) begin
        checks++;
        if (frame_err !== 1'b0 || bin_index !== 11'd30) begin
          errors++;
          $display("FAIL early_eop_pre: actual err=%b idx=%0d required 0/30", frame_err, bin_index);
        end
      end
    end
    src_idle();
    checks++;
    if (frame_err !== 1'b1 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL early_eop: actual err=%b cnt=%0d required 1/1", frame_err, frame_count);
    end
    src_beat(1'b1, 1'b0, 2'b01);
    src_idle();
    checks++;
    if (frame_err !== 1'b1 || frame_count !== 16'd1 || bin_index !== 11'd1) begin
      errors++;
      $display("FAIL src_error_beat: actual err=%b cnt=%0d idx=%0d required 1/1/1",
               frame_err, frame_count, bin_index);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0 || frame_count !== 16'd0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears: actual err=%b cnt=%0d cfg_err=%b required 0/0/0",
               frame_err, frame_count, cfg_err);
    end
    src_beat(1'b1, 1'b0, 2'b01);
    src_idle();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL src_error_only: actual=%b required 1", frame_err);
    end
    do_reset();
    src_beat(1'b1, 1'b0, 2'b00);
    src_beat(1'b1, 1'b0, 2'b00);
    src_idle();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL late_sop: actual=%b required 1", frame_err);
    end
    do_reset();
    src_beat(1'b1, 1'b1, 2'b00);
    src_idle();
    checks++;
    if (frame_err !== 1'b1 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL sop_eop_same_beat: actual err=%b cnt=%0d required 1/1",
               frame_err, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_stall();
    test_reconfig();
    test_enable_drop();
    test_illegal_cfg();
    test_reset_midframe();
    test_source_clean();
    test_source_errors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
